// File: rtl/rv_core_pkg.sv
// Shared types for the multicycle RV32I core: decoder opcode map, IR field view,
// sequencer states, writeback select and trap causes.
package rv_core_pkg;

  // One-hot opcode class from the decoder; exactly one bit is set for a recognised opcode.
  typedef struct packed {
    logic system;
    logic jal;
    logic jalr;
    logic branch;
    logic lui;
    logic op;
    logic store;
    logic auipc;
    logic op_imm;
    logic misc_mem;
    logic load_fp;
    logic load;
  } opcode_map;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_field;

  typedef enum logic [3:0] {
    FETCH, FWAIT, DECODE, EXEC, MEM_RD, MWAIT, MEM_WR, WB, TRAP
  } seq_state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    CAUSE_ILLEGAL      = 2'd0,
    CAUSE_MISALIGNED   = 2'd1,
    CAUSE_OUT_OF_RANGE = 2'd2,
    CAUSE_ECALL        = 2'd3
  } trap_cause_e;

  localparam logic [2:0] FUNCT3_W = 3'b010;

endpackage

// File: rtl/mc_next_pc.sv
// Next-pc selection for the sequencer: taken target vs pc+4, JALR bit0 clear,
// and the alignment / range checks on control targets and data addresses.
module mc_next_pc #(
  parameter int unsigned IMEM_WORDS = 2560,
  parameter int unsigned DMEM_WORDS = 2560
) (
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic        is_jalr,
  input  logic        take_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        tgt_misaligned,
  output logic        tgt_out_of_range,
  output logic        addr_misaligned,
  output logic        addr_out_of_range
);

  localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);
  localparam logic [29:0] DMEM_LIMIT = 30'(DMEM_WORDS);

  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;
  assign target   = is_jalr ? {alu_result[31:1], 1'b0} : alu_result;
  assign next_pc  = take_target ? target : pc_plus4;

  // Only bit1 matters for targets: instructions are 4-byte aligned and bit0 is never fetched.
  assign tgt_misaligned    = take_target && target[1];
  assign tgt_out_of_range  = take_target && (target[31:2] >= IMEM_LIMIT);
  assign addr_misaligned   = alu_result[1:0] != 2'b00;
  assign addr_out_of_range = alu_result[31:2] >= DMEM_LIMIT;

endmodule

// File: rtl/mc_core_sequencer.sv
// Multicycle control FSM for the RV32I core: owns pc/ir, sequences
// fetch/decode/execute/mem/writeback and captures a sticky trap.
module mc_core_sequencer
  import rv_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 2560,
  parameter int unsigned DMEM_WORDS = 2560
) (
  input  logic        clk,
  input  logic        rst_n,
  input  opcode_map   op_decode_pkt,
  input  logic [31:0] alu_result,
  input  logic        branch_taken,
  input  logic [31:0] rs2_val,
  output logic [31:0] imem_rd_addr,
  input  logic [31:0] imem_rd_data,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] dmem_rd_addr,
  input  logic [31:0] dmem_rd_data,
  output logic [31:0] dmem_wr_addr,
  output logic [31:0] dmem_wr_data,
  output logic        dmem_wren,
  output logic        rd_we,
  output wb_sel_e     rd_wsel,
  output logic [31:0] load_data,
  output logic        retire,
  output logic        trap,
  output trap_cause_e trap_cause,
  output logic [31:0] trap_pc
);

  seq_state_e  state;
  instr_field  ir_q;
  logic [31:0] wb_pc;

  logic        pkt_onehot, pkt_known, is_mem, take_target;
  logic        trap_now;
  trap_cause_e cause_c;

  logic [31:0] pc_plus4, next_pc;
  logic        tgt_misaligned, tgt_out_of_range, addr_misaligned, addr_out_of_range;

  mc_next_pc #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS)
  ) u_next_pc (
    .pc               (pc),
    .alu_result       (alu_result),
    .is_jalr          (op_decode_pkt.jalr),
    .take_target      (take_target),
    .pc_plus4         (pc_plus4),
    .next_pc          (next_pc),
    .tgt_misaligned   (tgt_misaligned),
    .tgt_out_of_range (tgt_out_of_range),
    .addr_misaligned  (addr_misaligned),
    .addr_out_of_range(addr_out_of_range)
  );

  assign pkt_onehot = $onehot(op_decode_pkt);
  assign pkt_known  = op_decode_pkt.op   | op_decode_pkt.op_imm | op_decode_pkt.lui   |
                      op_decode_pkt.auipc | op_decode_pkt.jal   | op_decode_pkt.jalr  |
                      op_decode_pkt.branch | op_decode_pkt.load | op_decode_pkt.store |
                      op_decode_pkt.system;
  assign is_mem      = op_decode_pkt.load | op_decode_pkt.store;
  assign take_target = pkt_onehot &&
                       (op_decode_pkt.jal || op_decode_pkt.jalr ||
                        (op_decode_pkt.branch && branch_taken));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    trap_now = 1'b0;
    cause_c  = CAUSE_ILLEGAL;
    if (!pkt_onehot || !pkt_known || (is_mem && ir_q.funct3 != FUNCT3_W)) begin
      trap_now = 1'b1;
      cause_c  = CAUSE_ILLEGAL;
    end else if (op_decode_pkt.system) begin
      trap_now = 1'b1;
      cause_c  = CAUSE_ECALL;
    end else if ((is_mem && addr_misaligned) || tgt_misaligned) begin
      trap_now = 1'b1;
      cause_c  = CAUSE_MISALIGNED;
    end else if ((is_mem && addr_out_of_range) || tgt_out_of_range) begin
      trap_now = 1'b1;
      cause_c  = CAUSE_OUT_OF_RANGE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      ir_q       <= '0;
      load_data  <= '0;
      wb_pc      <= '0;
      rd_wsel    <= WB_ALU;
      trap       <= 1'b0;
      trap_cause <= CAUSE_ILLEGAL;
      trap_pc    <= '0;
    end else begin
      case (state)
        FETCH:  state <= FWAIT;
        FWAIT: begin
          ir_q  <= instr_field'(imem_rd_data);
          state <= DECODE;
        end
        DECODE: state <= EXEC;
        EXEC: begin
          wb_pc <= next_pc;
          if (trap_now) begin
            state      <= TRAP;
            trap       <= 1'b1;
            trap_cause <= cause_c;
            trap_pc    <= pc;
          end else if (op_decode_pkt.branch) begin
            pc    <= next_pc;
            state <= FETCH;
          end else if (op_decode_pkt.load) begin
            rd_wsel <= WB_MEM;
            state   <= MEM_RD;
          end else if (op_decode_pkt.store) begin
            state <= MEM_WR;
          end else if (op_decode_pkt.jal || op_decode_pkt.jalr) begin
            rd_wsel <= WB_PC4;
            state   <= WB;
          end else begin
            rd_wsel <= WB_ALU;
            state   <= WB;
          end
        end
        MEM_RD: state <= MWAIT;
        MWAIT: begin
          load_data <= dmem_rd_data;
          state     <= WB;
        end
        MEM_WR: begin
          pc    <= pc_plus4;
          state <= FETCH;
        end
        WB: begin
          pc    <= wb_pc;
          state <= FETCH;
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are pure state decodes so an asynchronous reset kills them immediately.
  assign dmem_wren = (state == MEM_WR);
  assign rd_we     = (state == WB) && (ir_q.rd != 5'd0);
  assign retire    = (state == WB) || (state == MEM_WR) ||
                     ((state == EXEC) && op_decode_pkt.branch && !trap_now);

  assign ir           = ir_q;
  assign imem_rd_addr = {2'b00, pc[31:2]};
  assign dmem_rd_addr = {2'b00, alu_result[31:2]};
  assign dmem_wr_addr = {2'b00, alu_result[31:2]};
  assign dmem_wr_data = rs2_val;

endmodule

// File: tb/tb_mc_core_sequencer.sv
// Self-checking bench for mc_core_sequencer: directed table, multi-cycle corner
// sequences, and random instructions against a behavioural reference model.
module tb_mc_core_sequencer;
  import rv_core_pkg::*;

  localparam int IMEM_W = 2560;
  localparam int DMEM_W = 2560;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  opcode_map   pkt;
  logic [31:0] alu_result, rs2_val, imem_rd_data, dmem_rd_data;
  logic        branch_taken;
  logic [31:0] imem_rd_addr, ir, pc, dmem_rd_addr, dmem_wr_addr, dmem_wr_data, load_data, trap_pc;
  logic        dmem_wren, rd_we, retire, trap;
  logic [1:0]  rd_wsel, trap_cause;

  mc_core_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_decode_pkt(pkt), .alu_result(alu_result),
    .branch_taken(branch_taken), .rs2_val(rs2_val), .imem_rd_addr(imem_rd_addr),
    .imem_rd_data(imem_rd_data), .ir(ir), .pc(pc), .dmem_rd_addr(dmem_rd_addr),
    .dmem_rd_data(dmem_rd_data), .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
    .dmem_wren(dmem_wren), .rd_we(rd_we), .rd_wsel(rd_wsel), .load_data(load_data),
    .retire(retire), .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc)
  );

  always #5 clk = ~clk;

  // Sync-read memories with one cycle of latency; imem simply returns the current instruction.
  logic [31:0] cur_instr = 32'h0;
  logic [31:0] dmem [0:4095];
  always @(posedge clk) begin
    imem_rd_data <= cur_instr;
    dmem_rd_data <= dmem[dmem_rd_addr[11:0]];
    if (dmem_wren) dmem[dmem_wr_addr[11:0]] <= dmem_wr_data;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          trap;
    logic [1:0]  cause;
    int          cycles;
    bit          we;
    logic [1:0]  wsel;
    bit          wren;
    bit          is_load;
    logic [31:0] npc;
  } exp_t;

  typedef struct {
    bit          done;
    int          cycles;
    int          we_cnt;
    logic [1:0]  wsel;
    int          wren_cnt;
    int          retire_cnt;
    logic [31:0] wr_addr, wr_data, imem_addr, rd_addr, ir, load_data, pc_after, trap_pc;
    logic        trap;
    logic [1:0]  cause;
  } obs_t;

  logic [31:0] ref_mem [int];

  function automatic logic [31:0] init_word(input int idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] mem_word(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  function automatic exp_t ok_e(input int cyc, input bit we, input logic [1:0] wsel,
                                input bit wren, input bit ld, input logic [31:0] npc);
    exp_t e;
    e = '{trap: 0, cause: 0, cycles: cyc, we: we, wsel: wsel, wren: wren, is_load: ld, npc: npc};
    return e;
  endfunction

  function automatic exp_t trap_e(input logic [1:0] cause);
    exp_t e;
    e = '{trap: 1, cause: cause, cycles: 0, we: 0, wsel: 0, wren: 0, is_load: 0, npc: 0};
    return e;
  endfunction

  // Architectural outcome of one instruction, straight from the class rules.
  function automatic exp_t model(input logic [31:0] pc0, input opcode_map p,
                                 input logic [31:0] instr, input logic [31:0] alu, input bit bt);
    int          hot    = $countones(p);
    bit          mem_op = p.load || p.store;
    bit          jump   = p.jal || p.jalr || (p.branch && bt);
    bit          known  = p.op || p.op_imm || p.lui || p.auipc || p.jal || p.jalr ||
                          p.branch || p.load || p.store || p.system;
    logic [31:0] tgt    = p.jalr ? alu - (alu % 2) : alu;
    bit          writes = instr[11:7] != 0;
    if (hot != 1 || !known || (mem_op && instr[14:12] != 3'd2)) return trap_e(2'd0);
    if (p.system) return trap_e(2'd3);
    if ((mem_op && alu % 4 != 0) || (jump && tgt % 4 >= 2)) return trap_e(2'd1);
    if ((mem_op && alu / 4 >= DMEM_W) || (jump && tgt / 4 >= IMEM_W)) return trap_e(2'd2);
    if (p.branch) return ok_e(4, 0, 2'd0, 0, 0, jump ? tgt : pc0 + 4);
    if (p.store)  return ok_e(5, 0, 2'd0, 1, 0, pc0 + 4);
    if (p.load)   return ok_e(7, writes, 2'd1, 0, 1, pc0 + 4);
    if (p.jal || p.jalr) return ok_e(5, writes, 2'd2, 0, 0, tgt);
    return ok_e(5, writes, 2'd0, 0, 0, pc0 + 4);
  endfunction

  // ---------------- drivers ----------------
  // Reset is released just after a rising edge so the caller starts inside the FETCH cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input opcode_map p, input logic [31:0] instr, input logic [31:0] alu,
                           input bit bt, input logic [31:0] rs2, output obs_t o);
    o = '{default: 0};
    pkt = p; cur_instr = instr; alu_result = alu; branch_taken = bt; rs2_val = rs2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) o.imem_addr = imem_rd_addr;
      if (rd_we) begin o.we_cnt++; o.wsel = rd_wsel; end
      if (dmem_wren) begin o.wren_cnt++; o.wr_addr = dmem_wr_addr; o.wr_data = dmem_wr_data; end
      if (retire) begin o.retire_cnt++; o.cycles = c; end
      if (retire || trap) begin o.done = 1; break; end
    end
    o.trap = trap; o.cause = trap_cause; o.trap_pc = trap_pc;
    o.ir = ir; o.load_data = load_data; o.rd_addr = dmem_rd_addr;
    if (o.retire_cnt > 0) begin
      @(posedge clk); #1;
    end
    o.pc_after = pc;
  endtask

  task automatic exec_check(input string nm, input opcode_map p, input logic [31:0] instr,
                            input logic [31:0] alu, input bit bt, input logic [31:0] rs2,
                            input exp_t e, input logic [31:0] pc0);
    obs_t o;
    run_instr(p, instr, alu, bt, rs2, o);
    check({nm, " finished"}, 32'(o.done), 32'd1);
    check({nm, " imem_rd_addr"}, o.imem_addr, pc0 >> 2);
    check({nm, " ir"}, o.ir, instr);
    check({nm, " trap"}, 32'(o.trap), 32'(e.trap));
    check({nm, " rd_we count"}, 32'(o.we_cnt), 32'(e.we));
    check({nm, " dmem_wren count"}, 32'(o.wren_cnt), 32'(e.wren));
    if (e.trap) begin
      check({nm, " trap_cause"}, 32'(o.cause), 32'(e.cause));
      check({nm, " trap_pc"}, o.trap_pc, pc0);
      check({nm, " retire count"}, 32'(o.retire_cnt), 32'd0);
      check({nm, " pc held"}, o.pc_after, pc0);
    end else begin
      check({nm, " cycles"}, 32'(o.cycles), 32'(e.cycles));
      check({nm, " pc after"}, o.pc_after, e.npc);
      if (e.we) check({nm, " rd_wsel"}, 32'(o.wsel), 32'(e.wsel));
      if (e.wren) begin
        check({nm, " wr_addr"}, o.wr_addr, alu >> 2);
        check({nm, " wr_data"}, o.wr_data, rs2);
        ref_mem[int'(alu >> 2)] = rs2;
      end
      if (e.is_load) begin
        check({nm, " dmem_rd_addr"}, o.rd_addr, alu >> 2);
        check({nm, " load_data"}, o.load_data, mem_word(int'(alu >> 2)));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    string       name;
    opcode_map   p;
    logic [31:0] instr;
    logic [31:0] alu;
    bit          bt;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  opcode_map P_LOAD, P_LOAD_FP, P_MISC, P_OPIMM, P_AUIPC, P_STORE, P_OP, P_LUI,
             P_BRANCH, P_JALR, P_JAL, P_SYSTEM, P_NONE, P_MULTI;
  opcode_map classes [12];
  vec_t      vt [$];

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    obs_t        o;
    int          bad, seen;
    logic [31:0] pc_before, model_pc;

    for (int i = 0; i < 4096; i++) dmem[i] = init_word(i);
    dmem[2] = 32'hDEAD_BEEF;
    ref_mem[2] = 32'hDEAD_BEEF;

    P_LOAD = '0;   P_LOAD.load = 1'b1;       P_LOAD_FP = '0; P_LOAD_FP.load_fp = 1'b1;
    P_MISC = '0;   P_MISC.misc_mem = 1'b1;   P_OPIMM = '0;   P_OPIMM.op_imm = 1'b1;
    P_AUIPC = '0;  P_AUIPC.auipc = 1'b1;     P_STORE = '0;   P_STORE.store = 1'b1;
    P_OP = '0;     P_OP.op = 1'b1;           P_LUI = '0;     P_LUI.lui = 1'b1;
    P_BRANCH = '0; P_BRANCH.branch = 1'b1;   P_JALR = '0;    P_JALR.jalr = 1'b1;
    P_JAL = '0;    P_JAL.jal = 1'b1;         P_SYSTEM = '0;  P_SYSTEM.system = 1'b1;
    P_NONE = '0;   P_MULTI = P_OP | P_OPIMM;
    classes = '{P_LOAD, P_LOAD_FP, P_MISC, P_OPIMM, P_AUIPC, P_STORE,
                P_OP, P_LUI, P_BRANCH, P_JALR, P_JAL, P_SYSTEM};
    pkt = P_NONE; alu_result = '0; branch_taken = 1'b0; rs2_val = '0;

    // Directed table; every entry starts from reset at pc 0.
    vt.push_back('{"addi_x1",      P_OPIMM,  32'h0050_0093, 32'd5,      1'b0, 32'd0, ok_e(5, 1, 2'd0, 0, 0, 32'h4)});
    vt.push_back('{"addi_x0",      P_OPIMM,  32'h0000_0013, 32'd7,      1'b0, 32'd0, ok_e(5, 0, 2'd0, 0, 0, 32'h4)});
    vt.push_back('{"lw_x2_8",      P_LOAD,   32'h0080_2103, 32'd8,      1'b0, 32'd0, ok_e(7, 1, 2'd1, 0, 1, 32'h4)});
    vt.push_back('{"sw_12",        P_STORE,  32'h0000_2623, 32'd12,     1'b0, 32'h1234_5678, ok_e(5, 0, 2'd0, 1, 0, 32'h4)});
    vt.push_back('{"beq_taken",    P_BRANCH, 32'h0400_0063, 32'h40,     1'b1, 32'd0, ok_e(4, 0, 2'd0, 0, 0, 32'h40)});
    vt.push_back('{"beq_not",      P_BRANCH, 32'h0400_0063, 32'h42,     1'b0, 32'd0, ok_e(4, 0, 2'd0, 0, 0, 32'h4)});
    vt.push_back('{"jal_x1",       P_JAL,    32'h0000_00EF, 32'h100,    1'b0, 32'd0, ok_e(5, 1, 2'd2, 0, 0, 32'h100)});
    vt.push_back('{"jalr_bit0",    P_JALR,   32'h0000_80E7, 32'h81,     1'b0, 32'd0, ok_e(5, 1, 2'd2, 0, 0, 32'h80)});
    vt.push_back('{"beq_last_wd",  P_BRANCH, 32'h0400_0063, 32'h27FC,   1'b1, 32'd0, ok_e(4, 0, 2'd0, 0, 0, 32'h27FC)});
    vt.push_back('{"lw_last_wd",   P_LOAD,   32'h0000_2183, 32'h27FC,   1'b0, 32'd0, ok_e(7, 1, 2'd1, 0, 1, 32'h4)});
    vt.push_back('{"lw_misalign",  P_LOAD,   32'h0060_2103, 32'd6,      1'b0, 32'd0, trap_e(2'd1)});
    vt.push_back('{"lw_oor",       P_LOAD,   32'h0000_2103, 32'd10240,  1'b0, 32'd0, trap_e(2'd2)});
    vt.push_back('{"lw_mis_oor",   P_LOAD,   32'h0000_2103, 32'd10238,  1'b0, 32'd0, trap_e(2'd1)});
    vt.push_back('{"load_fp",      P_LOAD_FP,32'h0000_2007, 32'd8,      1'b0, 32'd0, trap_e(2'd0)});
    vt.push_back('{"lh_misalign",  P_LOAD,   32'h0060_1103, 32'd6,      1'b0, 32'd0, trap_e(2'd0)});
    vt.push_back('{"sb_illegal",   P_STORE,  32'h0000_0623, 32'd12,     1'b0, 32'd0, trap_e(2'd0)});
    vt.push_back('{"ecall",        P_SYSTEM, 32'h0000_0073, 32'd0,      1'b0, 32'd0, trap_e(2'd3)});
    vt.push_back('{"pkt_zero",     P_NONE,   32'h0000_0013, 32'd0,      1'b0, 32'd0, trap_e(2'd0)});
    vt.push_back('{"pkt_multi",    P_MULTI,  32'h0000_0013, 32'd0,      1'b0, 32'd0, trap_e(2'd0)});
    vt.push_back('{"misc_mem",     P_MISC,   32'h0000_000F, 32'd0,      1'b0, 32'd0, trap_e(2'd0)});
    vt.push_back('{"beq_oor",      P_BRANCH, 32'h0400_0063, 32'h2800,   1'b1, 32'd0, trap_e(2'd2)});
    vt.push_back('{"jal_mis",      P_JAL,    32'h0000_00EF, 32'h102,    1'b0, 32'd0, trap_e(2'd1)});
    vt.push_back('{"jalr_mis",     P_JALR,   32'h0000_80E7, 32'h103,    1'b0, 32'd0, trap_e(2'd1)});

    foreach (vt[i]) begin
      do_reset();
      exec_check(vt[i].name, vt[i].p, vt[i].instr, vt[i].alu, vt[i].bt, vt[i].rs2, vt[i].e, 32'h0);
    end

    // Trap is absorbing for 100 cycles, then reset clears all trap state.
    do_reset();
    exec_check("absorb_lw", P_LOAD, 32'h0060_2103, 32'd6, 1'b0, 32'd0, trap_e(2'd1), 32'h0);
    pkt = P_OPIMM; cur_instr = 32'h0050_0093; alu_result = 32'd4;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (rd_we || dmem_wren || retire || !trap || pc != 32'h0) bad++;
    end
    check("trap absorbing violations", 32'(bad), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("reset pc", pc, 32'h0);
    check("reset ir", ir, 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset trap", 32'(trap), 32'd0);
    check("reset trap_cause", 32'(trap_cause), 32'd0);
    check("reset trap_pc", trap_pc, 32'h0);
    check("reset strobes", {29'd0, rd_we, retire, dmem_wren}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exec_check("post_reset_addi", P_OPIMM, 32'h0050_0093, 32'd5, 1'b0, 32'd0,
               ok_e(5, 1, 2'd0, 0, 0, 32'h4), 32'h0);

    // Reset asserted in the middle of the store cycle.
    do_reset();
    exec_check("pre_store_addi", P_OPIMM, 32'h0010_0093, 32'd1, 1'b0, 32'd0,
               ok_e(5, 1, 2'd0, 0, 0, 32'h4), 32'h0);
    pkt = P_STORE; cur_instr = 32'h0000_2623; alu_result = 32'd16; rs2_val = 32'hCAFE_0001;
    seen = 0;
    for (int c = 0; c < 12 && seen == 0; c++) begin
      @(negedge clk);
      if (dmem_wren) seen = 1;
    end
    check("store strobe reached", 32'(seen), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("wren drops at reset", 32'(dmem_wren), 32'd0);
    check("retire drops at reset", 32'(retire), 32'd0);
    check("pc reset mid store", pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exec_check("addi_x0_after", P_OPIMM, 32'h0000_0013, 32'd3, 1'b0, 32'd0,
               ok_e(5, 0, 2'd0, 0, 0, 32'h4), 32'h0);

    // Random instruction stream against the reference model.
    do_reset();
    model_pc = 32'h0;
    for (int n = 0; n < 400; n++) begin
      opcode_map   p;
      logic [31:0] instr, alu, rs2;
      bit          bt;
      int          k, r;
      exp_t        e;
      k = $urandom_range(0, 13);
      if (k < 12) p = classes[k];
      else if (k == 12) p = P_NONE;
      else p = classes[$urandom_range(0, 5)] | classes[$urandom_range(6, 11)];
      instr = $urandom;
      if ($urandom_range(0, 3) != 0) instr[14:12] = 3'b010;
      r = $urandom_range(0, 9);
      if (r < 6)       alu = 32'($urandom_range(0, DMEM_W - 1)) * 4;
      else if (r == 6) alu = 32'($urandom_range(0, 4 * DMEM_W - 1)) | 32'd1;
      else if (r == 7) alu = 32'($urandom_range(DMEM_W, 4095)) * 4;
      else if (r == 8) alu = 32'($urandom_range(0, DMEM_W - 1)) * 4 + 2;
      else             alu = $urandom;
      bt  = 1'($urandom_range(0, 1));
      rs2 = $urandom;
      e = model(model_pc, p, instr, alu, bt);
      pc_before = model_pc;
      exec_check($sformatf("rand%0d", n), p, instr, alu, bt, rs2, e, pc_before);
      if (e.trap) begin
        do_reset();
        model_pc = 32'h0;
      end else begin
        model_pc = e.npc;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
